// File: rtl/sp_ram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter.
// Contents: owner state encoding, port identifiers, and a small
// helper that maps a port ID to its owner state.
`timescale 1ns/1ps
package sp_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic owner_e port_owner(input logic port);
        return (port == PORT_B) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/rr_burst_pick.sv
// Combinational grantee selection for the two-port RAM arbiter.
// Ports:
//   owner      current owner state (IDLE / OWN_A / OWN_B)
//   burst_cnt  consecutive grants given to the current owner
//   last       last port served (breaks ties from IDLE)
//   req_a/b    port requests
//   grant      a port is granted this cycle
//   port       granted port ID (valid when grant=1)
//   extend     grant continues the current owner's burst (count increments);
//              0 on a new owner or a sole-requester restart (count reloads to 1)
`timescale 1ns/1ps
module rr_burst_pick
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  owner_e           owner,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             last,
    input  logic             req_a,
    input  logic             req_b,
    output logic             grant,
    output logic             port,
    output logic             extend
);

    logic own_port;
    logic req_own;
    logic req_oth;
    logic below_limit;

    assign own_port    = (owner == OWN_B) ? PORT_B : PORT_A;
    assign req_own     = (own_port == PORT_B) ? req_b : req_a;
    assign req_oth     = (own_port == PORT_B) ? req_a : req_b;
    assign below_limit = burst_cnt < CNT_W'(MAX_BURST);

    always_comb begin
        grant  = 1'b0;
        port   = PORT_A;
        extend = 1'b0;
        unique case (owner)
            OWN_A, OWN_B: begin
                if (req_own && below_limit) begin
                    grant  = 1'b1;
                    port   = own_port;
                    extend = 1'b1;
                end else if (req_oth) begin
                    grant = 1'b1;
                    port  = ~own_port;
                end else if (req_own) begin
                    // Sole requester at the limit: keep it, but restart the burst.
                    grant = 1'b1;
                    port  = own_port;
                end
            end
            default: begin
                if (req_a && req_b) begin
                    grant = 1'b1;
                    port  = ~last;
                end else if (req_a) begin
                    grant = 1'b1;
                    port  = PORT_A;
                end else if (req_b) begin
                    grant = 1'b1;
                    port  = PORT_B;
                end
            end
        endcase
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of a
// single-port RAM (registered read, 1-cycle latency).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_x/we_x/addr_x/wdata_x  per-port access request (x = a, b)
//   gnt_x                      combinational grant, same cycle as req
//   rvalid_x                   read data valid, one cycle after a read grant
//   rdata                      RAM read data, qualified by rvalid_x
//   ram_en/ram_w_r/ram_add/ram_data_in   RAM control/data pins
//   ram_data_out               RAM read data input
`timescale 1ns/1ps
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_a,
    input  logic                     we_a,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]    wdata_a,
    input  logic                     req_b,
    input  logic                     we_b,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]    wdata_b,
    output logic                     gnt_a,
    output logic                     gnt_b,
    output logic                     rvalid_a,
    output logic                     rvalid_b,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     ram_en,
    output logic                     ram_w_r,
    output logic [ADDRESS_WIDTH-1:0] ram_add,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_q, last_d;
    logic             rvalid_a_q, rvalid_b_q;

    logic             pick_grant;
    logic             pick_port;
    logic             pick_extend;
    logic             grant;

    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;

    rr_burst_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .owner     (owner_q),
        .burst_cnt (burst_cnt_q),
        .last      (last_q),
        .req_a     (req_a),
        .req_b     (req_b),
        .grant     (pick_grant),
        .port      (pick_port),
        .extend    (pick_extend)
    );

    // Requests may already be high during reset; keep grants and RAM pins quiet.
    assign grant = pick_grant & rst_n;

    assign gnt_a = grant & (pick_port == PORT_A);
    assign gnt_b = grant & (pick_port == PORT_B);

    assign sel_we    = (pick_port == PORT_B) ? we_b    : we_a;
    assign sel_addr  = (pick_port == PORT_B) ? addr_b  : addr_a;
    assign sel_wdata = (pick_port == PORT_B) ? wdata_b : wdata_a;

    always_comb begin
        ram_en      = grant;
        ram_w_r     = grant & sel_we;
        ram_add     = grant ? sel_addr  : '0;
        ram_data_in = grant ? sel_wdata : '0;
    end

    always_comb begin
        owner_d     = IDLE;
        burst_cnt_d = '0;
        last_d      = last_q;
        if (grant) begin
            owner_d     = port_owner(pick_port);
            burst_cnt_d = pick_extend ? burst_cnt_q + 1'b1 : CNT_W'(1);
            last_d      = pick_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= IDLE;
            burst_cnt_q <= '0;
            last_q      <= PORT_B;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            rvalid_a_q  <= gnt_a & ~we_a;
            rvalid_b_q  <= gnt_b & ~we_b;
        end
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata    = ram_data_out;

endmodule
